// File: rtl/lane_run_ctrl.sv
// -----------------------------------------------------------------------------
// lane_run_ctrl
//
// Run controller for an emulation platform. It sequences the shared system
// reset and the per-lane resets, releases each lane on its first clock-enable
// pulse, runs until emulated time reaches the stop time, and reports
// completion. An optional watchdog (macro LANE_TIMEOUT_EN) flags lanes that
// never come out of reset.
//
// Parameters
//   N_LANES        number of TX/RX lanes whose resets are sequenced
//   TIME_WIDTH     width of the emulated-time words (unsigned)
//   RST_CYCLES     clk_sys cycles rst_sys is held in SYS_RST (>= 1)
//   TIMEOUT_CYCLES lane-release watchdog limit (used with LANE_TIMEOUT_EN)
//
// Ports
//   clk_sys      in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   start        in   level; requests a run from IDLE, DONE or ERROR
//   abort        in   level; returns the block to IDLE (highest priority)
//   time_curr    in   current emulated time
//   time_stop    in   emulated stop time, sampled every cycle
//   cke_lane     in   per-lane clock-enable pulses
//   rst_sys      out  active-high reset for shared clk_sys logic
//   rst_lane     out  active-high per-lane resets
//   running      out  high while in RUN
//   sim_done     out  high while in DONE
//   timeout_err  out  high while in ERROR (tied low without LANE_TIMEOUT_EN)
//   state        out  IDLE=0 SYS_RST=1 LANE_REL=2 RUN=3 DONE=4 ERROR=5
//
// Configuration
//   `define LANE_TIMEOUT_EN  enables the LANE_REL watchdog and the ERROR state.
//
// All outputs are registered: they are decoded from the next state and loaded
// on the same edge as the state register, so each one moves exactly one cycle
// after the event that causes it.
// -----------------------------------------------------------------------------
module lane_run_ctrl #(
  parameter int N_LANES        = 2,
  parameter int TIME_WIDTH     = 32,
  parameter int RST_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk_sys,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [TIME_WIDTH-1:0] time_curr,
  input  logic [TIME_WIDTH-1:0] time_stop,
  input  logic [N_LANES-1:0]    cke_lane,
  output logic                  rst_sys,
  output logic [N_LANES-1:0]    rst_lane,
  output logic                  running,
  output logic                  sim_done,
  output logic                  timeout_err,
  output logic [2:0]            state
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SYS_RST  = 3'd1,
    ST_LANE_REL = 3'd2,
    ST_RUN      = 3'd3,
    ST_DONE     = 3'd4,
    ST_ERROR    = 3'd5
  } state_e;

  // Hold counter counts RST_CYCLES-1 down to 0, so it only needs to hold
  // RST_CYCLES-1; keep at least one bit for RST_CYCLES == 1.
  localparam int HOLD_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(RST_CYCLES - 1);

  state_e              state_q;
  state_e              state_d;
  logic [HOLD_W-1:0]   hold_q;
  logic [HOLD_W-1:0]   hold_d;
  logic [N_LANES-1:0]  lane_d;
  logic [N_LANES-1:0]  lanes_left;

`ifdef LANE_TIMEOUT_EN
  // Watchdog counts 0 .. TIMEOUT_CYCLES-1 while in LANE_REL.
  localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] wd_q;
  logic [WD_W-1:0] wd_d;
`endif

  // Lanes still held in reset once this cycle's enable pulses are applied.
  // Only meaningful in LANE_REL, where rst_lane is the sticky release mask.
  assign lanes_left = rst_lane & ~cke_lane;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned; a missing default here would infer a latch.
    state_d = state_q;
    hold_d  = hold_q;
`ifdef LANE_TIMEOUT_EN
    wd_d    = wd_q;
`endif

    if (abort) begin
      // abort outranks start and every other transition.
      state_d = ST_IDLE;
      hold_d  = '0;
`ifdef LANE_TIMEOUT_EN
      wd_d    = '0;
`endif
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d = ST_SYS_RST;
            hold_d  = HOLD_LOAD;
          end
        end

        ST_SYS_RST: begin
          if (hold_q == '0) begin
            state_d = ST_LANE_REL;
`ifdef LANE_TIMEOUT_EN
            wd_d    = '0;
`endif
          end else begin
            hold_d = hold_q - 1'b1;
          end
        end

        ST_LANE_REL: begin
          // Release wins over a timeout landing on the same cycle.
          if (lanes_left == '0) begin
            state_d = ST_RUN;
`ifdef LANE_TIMEOUT_EN
          end else if (wd_q == WD_LAST) begin
            state_d = ST_ERROR;
          end else begin
            wd_d = wd_q + 1'b1;
`endif
          end
        end

        ST_RUN: begin
          if (time_curr >= time_stop) begin
            state_d = ST_DONE;
          end
        end

        ST_DONE: begin
          if (start) begin
            state_d = ST_SYS_RST;
            hold_d  = HOLD_LOAD;
          end
        end

`ifdef LANE_TIMEOUT_EN
        ST_ERROR: begin
          if (start) begin
            state_d = ST_SYS_RST;
            hold_d  = HOLD_LOAD;
          end
        end
`endif

        // Encodings 6 and 7 (and ERROR when the watchdog is absent) are
        // unreachable; recover to IDLE if one is ever decoded.
        default: begin
          state_d = ST_IDLE;
          hold_d  = '0;
        end
      endcase
    end

    // Lane reset mask for the next cycle. The mask only shrinks while staying
    // in LANE_REL; entering LANE_REL always starts from all lanes held.
    unique case (state_d)
      ST_LANE_REL: lane_d = (state_q == ST_LANE_REL) ? lanes_left : '1;
      ST_RUN,
      ST_DONE:     lane_d = '0;
      default:     lane_d = '1;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      hold_q      <= '0;
      rst_sys     <= 1'b1;
      rst_lane    <= '1;
      running     <= 1'b0;
      sim_done    <= 1'b0;
`ifdef LANE_TIMEOUT_EN
      wd_q        <= '0;
      timeout_err <= 1'b0;
`endif
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // here samples the pre-edge values, independent of statement order.
      state_q     <= state_d;
      hold_q      <= hold_d;
      rst_sys     <= !(state_d == ST_LANE_REL || state_d == ST_RUN ||
                       state_d == ST_DONE);
      rst_lane    <= lane_d;
      running     <= (state_d == ST_RUN);
      sim_done    <= (state_d == ST_DONE);
`ifdef LANE_TIMEOUT_EN
      wd_q        <= wd_d;
      timeout_err <= (state_d == ST_ERROR);
`endif
    end
  end

`ifndef LANE_TIMEOUT_EN
  assign timeout_err = 1'b0;
`endif

  assign state = state_q;

endmodule

// File: tb/tb_lane_run_ctrl.sv
// -----------------------------------------------------------------------------
// tb_lane_run_ctrl
//
// Self-checking bench for lane_run_ctrl (N_LANES=2, RST_CYCLES=4,
// TIMEOUT_CYCLES=16). Expectations come from a timeline model: lane i stays in
// reset through the LANE_REL cycle in which its enable pulse is presented,
// RUN ends the cycle after time_curr >= time_stop is presented, and outputs are
// decoded from the expected state code. Works with or without LANE_TIMEOUT_EN.
// -----------------------------------------------------------------------------
module tb_lane_run_ctrl;

  localparam int NL   = 2;
  localparam int TW   = 32;
  localparam int RSTC = 4;
  localparam int TOC  = 16;

  logic          clk_sys = 1'b0;
  logic          rst_n;
  logic          start;
  logic          abort;
  logic [TW-1:0] time_curr;
  logic [TW-1:0] time_stop;
  logic [NL-1:0] cke_lane;
  logic          rst_sys;
  logic [NL-1:0] rst_lane;
  logic          running;
  logic          sim_done;
  logic          timeout_err;
  logic [2:0]    state;

  int n_checks = 0;
  int n_pass   = 0;

  lane_run_ctrl #(
    .N_LANES        (NL),
    .TIME_WIDTH     (TW),
    .RST_CYCLES     (RSTC),
    .TIMEOUT_CYCLES (TOC)
  ) dut (
    .clk_sys     (clk_sys),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .time_curr   (time_curr),
    .time_stop   (time_stop),
    .cke_lane    (cke_lane),
    .rst_sys     (rst_sys),
    .rst_lane    (rst_lane),
    .running     (running),
    .sim_done    (sim_done),
    .timeout_err (timeout_err),
    .state       (state)
  );

  always #5 clk_sys = ~clk_sys;

  // Hard stop in case the sequence ever stalls.
  initial begin
    #2000000;
    $display("FAIL global_timeout: bench did not finish, checks passed %0d of %0d",
             n_pass, n_checks);
    $fatal(1, "global timeout");
  end

  // Advance one cycle; outputs are then stable 1 time unit after the edge.
  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Compare every output against what the given state code implies.
  task automatic expect_st(input string tag, input logic [2:0] st,
                           input logic [NL-1:0] rl);
    check({tag, ".state"},       64'(state),       64'(st));
    check({tag, ".rst_sys"},     64'(rst_sys),     64'(st == 3'd0 || st == 3'd1 || st == 3'd5));
    check({tag, ".rst_lane"},    64'(rst_lane),    64'(rl));
    check({tag, ".running"},     64'(running),     64'(st == 3'd3));
    check({tag, ".sim_done"},    64'(sim_done),    64'(st == 3'd4));
    check({tag, ".timeout_err"}, 64'(timeout_err), 64'(st == 3'd5));
  endtask

  // From IDLE/DONE/ERROR: pulse start and walk through SYS_RST. A stray enable
  // pulse in SYS_RST must be ignored. Leaves the bench in LANE_REL cycle 0.
  task automatic go_to_lane_rel(input string tag);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= RSTC; c++) begin
      expect_st({tag, ".sysrst"}, 3'd1, '1);
      cke_lane = (c == 2) ? NL'($urandom_range(1, (1 << NL) - 1)) : '0;
      tick();
    end
    cke_lane = '0;
  endtask

  // Lane i pulses its enable in LANE_REL cycle d[i]; its reset is expected
  // high through that cycle and low afterwards. RUN follows the last release.
  task automatic lane_release(input string tag, input int d0, input int d1);
    int d[NL];
    int mx;
    logic [NL-1:0] exp_rl;
    d[0] = d0;
    d[1] = d1;
    mx   = (d0 > d1) ? d0 : d1;
    for (int k = 0; k <= mx; k++) begin
      for (int i = 0; i < NL; i++) exp_rl[i] = (k <= d[i]);
      expect_st({tag, ".lanerel"}, 3'd2, exp_rl);
      for (int i = 0; i < NL; i++) cke_lane[i] = (k == d[i]);
      tick();
    end
    cke_lane = '0;
    expect_st({tag, ".run_entry"}, 3'd3, '0);
  endtask

  // In RUN: present time_curr = c0, c0+1, ... until one is >= stop; DONE must
  // follow on the next cycle.
  task automatic run_phase(input string tag, input logic [TW-1:0] stop,
                           input logic [TW-1:0] c0);
    logic [TW-1:0] cur;
    time_stop = stop;
    cur       = c0;
    for (int j = 0; j < 20; j++) begin
      time_curr = cur;
      expect_st({tag, ".run"}, 3'd3, '0);
      tick();
      if (cur >= stop) break;
      cur = cur + 1'b1;
    end
    expect_st({tag, ".done"}, 3'd4, '0);
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    time_curr = '0;
    time_stop = '0;
    cke_lane  = '0;

    // Reset state, then idle waiting for start.
    tick();
    tick();
    expect_st("reset", 3'd0, '1);
    @(negedge clk_sys);
    rst_n = 1'b1;
    repeat (3) tick();
    expect_st("idle_wait", 3'd0, '1);

    // Directed timeline: start at cycle 0, lane 0 at cycle 7, lane 1 at 10.
    start = 1'b1;
    tick();                                   // cycle 1
    start = 1'b0;
    expect_st("c1", 3'd1, '1);
    repeat (3) tick();                        // cycle 4
    expect_st("c4", 3'd1, '1);
    tick();                                   // cycle 5
    expect_st("c5", 3'd2, '1);
    tick();                                   // cycle 6
    tick();                                   // cycle 7
    cke_lane = 2'b01;
    tick();                                   // cycle 8
    cke_lane = 2'b00;
    expect_st("c8", 3'd2, 2'b10);
    tick();                                   // cycle 9
    tick();                                   // cycle 10
    cke_lane = 2'b10;
    tick();                                   // cycle 11
    cke_lane = 2'b00;
    expect_st("c11", 3'd3, 2'b00);

    // Stop-time compare: 990, 999, 1000.
    time_stop = 32'd1000;
    time_curr = 32'd990;
    tick();
    expect_st("t999_pre", 3'd3, '0);
    time_curr = 32'd999;
    tick();
    expect_st("t1000_pre", 3'd3, '0);
    time_curr = 32'd1000;
    tick();
    expect_st("t1000_done", 3'd4, '0);

    // Restart from DONE, simultaneous lane release, stop time already reached.
    go_to_lane_rel("zero_stop");
    lane_release("zero_stop", 3, 3);
    run_phase("zero_stop", 32'd0, 32'd0);

    // Restart from DONE: all resets reassert.
    start = 1'b1;
    tick();
    start = 1'b0;
    expect_st("restart", 3'd1, '1);
    repeat (RSTC) tick();
    expect_st("restart_lr", 3'd2, '1);
    lane_release("unsigned", 0, 1);
    // time_curr with MSB set must compare as a large unsigned value.
    run_phase("unsigned", 32'd5, 32'h8000_0000);

    // abort together with start in RUN.
    go_to_lane_rel("abort_run");
    lane_release("abort_run", 1, 0);
    time_stop = 32'hFFFF_FFFF;
    time_curr = 32'd0;
    tick();
    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    expect_st("abort_run", 3'd0, '1);

    // abort in LANE_REL after one lane has gone.
    go_to_lane_rel("abort_lr");
    cke_lane = 2'b10;
    tick();
    cke_lane = 2'b00;
    expect_st("abort_lr.pre", 3'd2, 2'b01);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    expect_st("abort_lr", 3'd0, '1);
    tick();
    expect_st("abort_lr.stay", 3'd0, '1);

    // Randomized runs against the timeline model.
    for (int it = 0; it < 12; it++) begin
      int d0, d1;
      logic [TW-1:0] stop;
      logic [TW-1:0] r;
      d0 = $urandom_range(0, 12);
      d1 = ($urandom_range(0, 3) == 0) ? d0 : $urandom_range(0, 12);
      go_to_lane_rel("rnd");
      lane_release("rnd", d0, d1);
      if ($urandom_range(0, 3) == 0) begin
        time_stop = 32'hFFFF_FFFF;
        time_curr = 32'd0;
        abort     = 1'b1;
        tick();
        abort     = 1'b0;
        expect_st("rnd.abort", 3'd0, '1);
      end else begin
        stop = $urandom;
        r    = TW'($urandom_range(0, 6));
        if (r > stop) r = stop;
        run_phase("rnd", stop, stop - r);
      end
    end

    // Lane 1 never released: watchdog (if built) or indefinite wait.
    go_to_lane_rel("wd");
    for (int k = 0; k < TOC; k++) begin
      expect_st("wd.wait", 3'd2, (k == 0) ? 2'b11 : 2'b10);
      cke_lane = (k == 0) ? 2'b01 : 2'b00;
      tick();
    end
    cke_lane = 2'b00;
`ifdef LANE_TIMEOUT_EN
    expect_st("wd.err", 3'd5, '1);
    tick();
    expect_st("wd.err_hold", 3'd5, '1);
    start = 1'b1;
    tick();
    start = 1'b0;
    expect_st("wd.restart", 3'd1, '1);
`else
    repeat (100 - TOC) tick();
    expect_st("wd.hold", 3'd2, 2'b10);
`endif
    abort = 1'b1;
    tick();
    abort = 1'b0;
    expect_st("wd.abort", 3'd0, '1);

    // Asynchronous reset in the middle of RUN, away from any clock edge.
    go_to_lane_rel("async");
    lane_release("async", 2, 4);
    time_stop = 32'hFFFF_FFFF;
    time_curr = 32'd0;
    tick();
    expect_st("async.pre", 3'd3, '0);
    #2;
    rst_n = 1'b0;
    #1;
    expect_st("async.rst", 3'd0, '1);
    @(negedge clk_sys);
    rst_n = 1'b1;
    repeat (3) tick();
    expect_st("async.idle", 3'd0, '1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/lane_run_ctrl.md
LANE_RUN_CTRL -- requirements
Module: lane_run_ctrl

Interface
REQ-001 Parameter N_LANES, default 2: number of TX/RX lanes whose resets are sequenced.
REQ-002 Parameter TIME_WIDTH, default 32: width of the emulated-time words, unsigned.
REQ-003 Parameter RST_CYCLES, default 4, minimum 1: clk_sys cycles rst_sys is held in SYS_RST.
REQ-004 Parameter TIMEOUT_CYCLES, default 1024: lane-release watchdog limit (REQ-021).
REQ-005 clk_sys  in  1  the single system clock; all logic is on its rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 start  in  1  level; requests a run from IDLE, DONE or ERROR.
REQ-008 abort  in  1  level; returns the block to IDLE.
REQ-009 time_curr  in  TIME_WIDTH  current emulated time from the time manager.
REQ-010 time_stop  in  TIME_WIDTH  stop time; sampled every cycle.
REQ-011 cke_lane  in  N_LANES  per-lane clock-enable pulses, one bit per lane.
REQ-012 rst_sys  out  1  active-high reset for shared clk_sys logic.
REQ-013 rst_lane  out  N_LANES  active-high per-lane resets.
REQ-014 running  out  1  high while in RUN.
REQ-015 sim_done  out  1  high while in DONE.
REQ-016 timeout_err  out  1  high while in ERROR.
REQ-017 state  out  3  encoding: IDLE=0, SYS_RST=1, LANE_REL=2, RUN=3, DONE=4, ERROR=5.

Function
REQ-018 All outputs are registered; every output changes one cycle after the state transition or event that causes it.
REQ-019 IDLE: rst_sys=1 and rst_lane=all-ones. start=1 moves to SYS_RST and loads the hold counter with RST_CYCLES-1.
REQ-020 SYS_RST: rst_sys=1 and rst_lane=all-ones. The counter decrements each cycle; at 0 the block moves to LANE_REL.
- rst_sys is therefore high for exactly RST_CYCLES cycles after leaving IDLE.
REQ-021 LANE_REL: rst_sys=0. rst_lane[i] clears the cycle after cke_lane[i]=1 is sampled and is sticky thereafter. Lanes are released independently.
- The block moves to RUN on the cycle when the last lane bit clears.
- When several cke_lane bits are high in the same cycle, all of those lanes are released together.
REQ-022 RUN: running=1, all resets low. When time_curr >= time_stop (unsigned), the block moves to DONE.
- If the condition already holds on entry, RUN lasts exactly one cycle.
REQ-023 DONE: sim_done=1 and resets remain low. start=1 moves to SYS_RST and reasserts all resets.
REQ-024 start is ignored in SYS_RST, LANE_REL and RUN.
REQ-025 abort=1 in any state other than IDLE forces IDLE on the next cycle: all resets asserted, running, sim_done and timeout_err cleared.
- abort has priority over start and over every other transition.
REQ-026 State values 6 and 7 are unreachable. If one is ever decoded, the block recovers to IDLE on the next cycle.

Reset
REQ-027 While rst_n=0, the block is in IDLE with rst_sys=1, rst_lane=all-ones, running=0, sim_done=0, timeout_err=0, and all counters at 0.
REQ-028 Asserting rst_n mid-operation takes effect immediately, without a clock edge. After rst_n deasserts, the block waits for start.

Configuration
REQ-029 Macro LANE_TIMEOUT_EN.
- Defined: a watchdog counts cycles spent in LANE_REL. If TIMEOUT_CYCLES cycles elapse without all lanes released, the block moves to ERROR.
- In ERROR: timeout_err=1, rst_sys=1, rst_lane=all-ones. ERROR is left via start (to SYS_RST) or abort (to IDLE).
- Undefined: LANE_REL waits indefinitely, ERROR is unreachable, timeout_err is tied to 0, and the watchdog logic is absent.

Verification
REQ-030 N_LANES=2, RST_CYCLES=4; pulse start at cycle 0 -> state=1 at cycle 1; rst_sys high through cycle 4 and 0 at cycle 5; state=2 at cycle 5.
REQ-031 In LANE_REL, pulse cke_lane=2'b01 at cycle 7 and 2'b10 at cycle 10 -> rst_lane=2'b10 at cycle 8, rst_lane=2'b00 and state=3 at cycle 11.
REQ-032 In RUN with time_stop=1000, step time_curr 990, 999, 1000 -> sim_done rises the cycle after 1000 is sampled; running falls on the same cycle.
REQ-033 Enter RUN with time_stop=0 -> running high for exactly 1 cycle, then sim_done=1. Then start -> state=1 and rst_lane=all-ones.
REQ-034 Assert abort and start together while in RUN -> state=0 next cycle, all resets asserted, sim_done=0.
REQ-035 With LANE_TIMEOUT_EN defined and TIMEOUT_CYCLES=16, never pulse cke_lane[1] -> state=5 and timeout_err=1 after 16 cycles in LANE_REL. Without the macro -> state stays 2 for 100 cycles. In both builds, rst_n=0 mid-run -> outputs reach their reset values immediately.
